// File: rtl/pipe_collision_scorer.sv
// Collision, pass counting and play/game-over control for the pipe animation.
// Pipe geometry checks are done per pipe in pipe_collision_lane instances.

module pipe_collision_lane #(
  parameter int BIRD_X = 100,
  parameter int BIRD_W = 34,
  parameter int BIRD_H = 24,
  parameter int PIPE_W = 52
) (
  input  logic       i_en,
  input  logic [9:0] i_x,
  input  logic [9:0] i_gap_top,
  input  logic [9:0] i_gap_bot,
  input  logic       i_up_vis,
  input  logic       i_down_vis,
  input  logic [9:0] i_bird_y,
  input  logic       i_passed,
  output logic       o_hit,
  output logic       o_pass
);
  logic [10:0] w_x_l, w_x_r, w_bird_b;
  logic        w_ovl;

  // 11-bit sums so a pipe near x=1023 does not wrap back onto the bird
  assign w_x_l    = {1'b0, i_x};
  assign w_x_r    = w_x_l + 11'(PIPE_W);
  assign w_bird_b = {1'b0, i_bird_y} + 11'(BIRD_H);
  assign w_ovl    = i_en && (w_x_l < 11'(BIRD_X + BIRD_W)) && (w_x_r > 11'(BIRD_X));
  assign o_hit    = w_ovl && ((i_up_vis && (i_bird_y < i_gap_top)) ||
                              (i_down_vis && (w_bird_b > {1'b0, i_gap_bot})));
  assign o_pass   = i_en && (w_x_r < 11'(BIRD_X)) && !i_passed;
endmodule

module pipe_collision_scorer #(
  parameter int BIRD_X    = 100,
  parameter int BIRD_W    = 34,
  parameter int BIRD_H    = 24,
  parameter int PIPE_W    = 52,
  parameter int SCREEN_H  = 480,
  parameter int MAX_SCORE = 999
) (
  input  logic       animationCLOCK,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] birdY,
  input  logic [9:0] pipe1X,
  input  logic [9:0] pipe1GapTop,
  input  logic [9:0] pipe1GapBottom,
  input  logic       pipe1UpVisible,
  input  logic       pipe1DownVisible,
  input  logic       pipe1En,
  input  logic [9:0] pipe2X,
  input  logic [9:0] pipe2GapTop,
  input  logic [9:0] pipe2GapBottom,
  input  logic       pipe2UpVisible,
  input  logic       pipe2DownVisible,
  input  logic       pipe2En,
  input  logic [9:0] pipe3X,
  input  logic [9:0] pipe3GapTop,
  input  logic [9:0] pipe3GapBottom,
  input  logic       pipe3UpVisible,
  input  logic       pipe3DownVisible,
  input  logic       pipe3En,
  output logic [9:0] score,
  output logic       scorePulse,
  output logic       playing,
  output logic       gameOver
);
  localparam int NUM_PIPES = 3;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_DEAD} state_t;

  state_t                          r_state, w_state_nxt;
  logic [9:0]                      r_score, w_score_nxt;
  logic                            r_pulse, w_pulse_nxt;
  logic                            r_playing, r_game_over;
  logic [NUM_PIPES-1:0]            r_passed, w_passed_nxt;

  logic [NUM_PIPES-1:0][9:0]       w_x, w_gt, w_gb;
  logic [NUM_PIPES-1:0]            w_en, w_uv, w_dv, w_hit, w_pass;
  logic [10:0]                     w_bird_b, w_sum;
  logic [9:0]                      w_sat;
  logic [1:0]                      w_cnt;
  logic                            w_floor, w_any_hit;

  assign w_x  = {pipe3X, pipe2X, pipe1X};
  assign w_gt = {pipe3GapTop, pipe2GapTop, pipe1GapTop};
  assign w_gb = {pipe3GapBottom, pipe2GapBottom, pipe1GapBottom};
  assign w_en = {pipe3En, pipe2En, pipe1En};
  assign w_uv = {pipe3UpVisible, pipe2UpVisible, pipe1UpVisible};
  assign w_dv = {pipe3DownVisible, pipe2DownVisible, pipe1DownVisible};

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_lane
    pipe_collision_lane #(
      .BIRD_X(BIRD_X), .BIRD_W(BIRD_W), .BIRD_H(BIRD_H), .PIPE_W(PIPE_W)
    ) u_lane (
      .i_en      (w_en[g]),
      .i_x       (w_x[g]),
      .i_gap_top (w_gt[g]),
      .i_gap_bot (w_gb[g]),
      .i_up_vis  (w_uv[g]),
      .i_down_vis(w_dv[g]),
      .i_bird_y  (birdY),
      .i_passed  (r_passed[g]),
      .o_hit     (w_hit[g]),
      .o_pass    (w_pass[g])
    );
  end

  assign w_bird_b  = {1'b0, birdY} + 11'(BIRD_H);
  assign w_floor   = w_bird_b >= 11'(SCREEN_H);
  assign w_any_hit = w_floor || (|w_hit);
  assign w_cnt     = 2'({1'b0, w_pass[0]} + {1'b0, w_pass[1]} + {1'b0, w_pass[2]});
  assign w_sum     = {1'b0, r_score} + 11'(w_cnt);
  assign w_sat     = (w_sum > 11'(MAX_SCORE)) ? 10'(MAX_SCORE) : w_sum[9:0];

  always_comb begin
    w_state_nxt  = r_state;
    w_score_nxt  = r_score;
    w_pulse_nxt  = 1'b0;
    // a disabled pipe forgets it was passed so its respawn can score again
    w_passed_nxt = r_passed & w_en;
    case (r_state)
      S_IDLE, S_DEAD: begin
        if (start) begin
          w_state_nxt  = S_PLAY;
          w_score_nxt  = '0;
          w_passed_nxt = '0;
        end
      end
      S_PLAY: begin
        if (w_any_hit) begin
          w_state_nxt = S_DEAD;
        end else begin
          w_passed_nxt = (r_passed | w_pass) & w_en;
          w_score_nxt  = w_sat;
          w_pulse_nxt  = (w_sat != r_score);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge animationCLOCK) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_score     <= '0;
      r_pulse     <= 1'b0;
      r_passed    <= '0;
      r_playing   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_score     <= w_score_nxt;
      r_pulse     <= w_pulse_nxt;
      r_passed    <= w_passed_nxt;
      r_playing   <= (w_state_nxt == S_PLAY);
      r_game_over <= (w_state_nxt == S_DEAD);
    end
  end

  assign score      = r_score;
  assign scorePulse = r_pulse;
  assign playing    = r_playing;
  assign gameOver   = r_game_over;
endmodule

// File: doc/pipe_collision_scorer.md
# pipe_collision_scorer

Downstream stage of the pipe animation block. Each `animationCLOCK` tick it consumes the three pipe positions, gap edges and visibility flags, plus the bird's vertical position. It detects bird/pipe and bird/floor collisions, counts pipes the bird has cleared, and runs the play/game-over state machine. Its `score` output feeds back into the pipe animation block, where it sets pipe speed and gap size.

## Interface
Parameters:
- BIRD_X, 100: fixed left edge of the bird, in pixels.
- BIRD_W, 34: bird width, in pixels.
- BIRD_H, 24: bird height, in pixels.
- PIPE_W, 52: pipe width, in pixels.
- SCREEN_H, 480: floor line, in pixels.
- MAX_SCORE, 999: saturation value of `score`.

Ports:
- animationCLOCK  in  1  sole clock, one tick per animation frame.
- reset  in  1  synchronous, active-high.
- start  in  1  level; starts or restarts a game.
- birdY  in  10  top edge of the bird.
- pipeNX  in  10  left edge of pipe N (N=1..3).
- pipeNGapTop  in  10  y where the upper pipe ends; the upper pipe occupies [0, gapTop).
- pipeNGapBottom  in  10  y where the lower pipe begins; the lower pipe occupies [gapBottom, SCREEN_H).
- pipeNUpVisible, pipeNDownVisible  in  1 each  visibility of each half of pipe N.
- pipeNEn  in  1  pipe N is active on screen.
- score  out  10  pipes cleared in the current game.
- scorePulse  out  1  one-cycle strobe on every score increment.
- playing  out  1  high in PLAY.
- gameOver  out  1  high in DEAD.

## Operation
- States: IDLE, PLAY, DEAD.
- Reset values: IDLE, score=0, scorePulse=0, playing=0, gameOver=0, all passed flags=0.
- IDLE:
  - start=1 moves to PLAY and sets score=0 and all passed flags to 0.
  - All other inputs are ignored.
- PLAY, horizontal overlap for pipe N (requires pipeNEn=1): pipeNX < BIRD_X+BIRD_W and pipeNX+PIPE_W > BIRD_X.
- PLAY, hit for pipe N: horizontal overlap and either
  - pipeNUpVisible and birdY < pipeNGapTop, or
  - pipeNDownVisible and birdY+BIRD_H > pipeNGapBottom.
- PLAY, floor hit: birdY+BIRD_H >= SCREEN_H.
- Any hit (pipe or floor) moves to DEAD. In that same cycle score does not change and scorePulse=0.
- PLAY, pass for pipe N: pipeNEn=1, pipeNX+PIPE_W < BIRD_X, and passedN=0.
  - Sets passedN=1.
  - Counts toward this cycle's increment.
- passedN clears whenever pipeNEn=0, so a respawned pipe can score again.
- Increment: the number of pipes passing this cycle (0–3) is added in one step. The result saturates at MAX_SCORE.
- scorePulse=1 only when score actually changes. At saturation, scorePulse=0.
- DEAD:
  - score holds.
  - gameOver=1.
  - start=1 moves to PLAY, clearing score and all passed flags, exactly as from IDLE.
- start is level-sensitive. Holding it high in PLAY has no effect.
- Arithmetic widths:
  - All coordinate sums (X+W, Y+H) are computed in 11 bits, so 1023+52 compares correctly without wrap.
  - The score sum is computed in 11 bits before saturation.

## Timing
- All outputs are registered. Inputs sampled at edge n appear on the outputs after edge n.
- Collision latency is 1 cycle: a hit sampled at edge n gives gameOver=1 and playing=0 after edge n.
- Score latency is 1 cycle. scorePulse is high for exactly 1 cycle per increment event.
- reset has priority over start and over all events. reset during PLAY returns to IDLE with score=0 on the next edge.
- Simultaneous hit and pass in one cycle: the hit wins and the pass is discarded.
- Simultaneous start and hit in IDLE or DEAD: start wins, and the hit check begins on the following cycle.

## Test plan
- **Reset and start:** reset, then start=1 for 1 cycle → playing=1, score=0, gameOver=0 on the next edge.
- **Single pass:** pipe1En=1, pipe1X stepping from 60 to 47 with birdY=200, gapTop=150, gapBottom=300 → at X=47 (47+52 < 100) score=1 with one scorePulse. Holding X=40 for further cycles gives no further increment.
- **Upper-pipe hit:** pipe1X=90, pipe1UpVisible=1, gapTop=220, birdY=200 → gameOver=1 one cycle later and score unchanged. A same-cycle pass on pipe2 is not counted.
- **Floor hit:** birdY=456 (456+24=480) → DEAD.
- **Multiple passes and saturation:**
  - Three pipes pass in the same cycle from score=5 → score=8 with a single scorePulse.
  - With score=998 and two passes → score=999.
  - A further pass at 999 → score stays 999 and scorePulse=0.
- **Respawn and restart:**
  - pipe1En drops to 0 and rises again, then pipe1 passes again → score increments again.
  - In DEAD, start=1 → PLAY with score=0.
  - reset mid-PLAY → IDLE with score=0.
